disc_layer3_feeder: RTL and testbench

- Initiator side of the discriminator layer-3 start/done interface.
- Accepts a serial valid/ready stream of Q8.8 activations from layer 2 and packs N_IN of them into the flat input bus.
- Pulses start to layer 3, waits for done (with a watchdog), captures score and decision, and presents them on a valid/ready result port.
- Sits between the layer-2 output serializer and layer3_discriminator.

---
 rtl/disc_layer3_feeder.sv | 145 ++++++++++++++
 tb/tb_disc_layer3_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/disc_layer3_feeder.sv
// Initiator side of the layer-3 start/done interface: packs N_IN serial Q8.8
// activations into a flat frame, starts layer 3 and returns its result.
module disc_layer3_feeder #(
    parameter int N_IN    = 32,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [N_IN*DATA_W-1:0] l3_flat_input,
    output logic                   l3_start,
    input  logic [DATA_W-1:0]      l3_score,
    input  logic                   l3_decision,
    input  logic                   l3_done,
    output logic [DATA_W-1:0]      res_score,
    output logic                   res_real,
    output logic                   res_timeout,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   frame_err
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_FIRE    = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_IN*DATA_W-1:0] flat_q, flat_d;
    logic                   start_q, start_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [DATA_W-1:0]      score_q, score_d;
    logic                   real_q, real_d;
    logic                   tmo_q, tmo_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;

    assign in_ready      = (state_q == S_COLLECT);
    assign l3_flat_input = flat_q;
    assign l3_start      = start_q;
    assign res_score     = score_q;
    assign res_real      = real_q;
    assign res_timeout   = tmo_q;
    assign res_valid     = valid_q;
    assign frame_err     = ferr_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        flat_d  = flat_q;
        start_d = 1'b0;
        timer_d = timer_q;
        score_d = score_q;
        real_d  = real_q;
        tmo_d   = tmo_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (in_valid) begin
                    for (int unsigned k = 0; k < N_IN; k++) begin
                        if (idx_q == IDX_W'(k)) flat_d[k*DATA_W +: DATA_W] = in_data;
                    end
                    // Length is authoritative: a full frame fires regardless of in_last.
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FIRE;
                        idx_d   = '0;
                        start_d = 1'b1;
                    end else if (in_last) begin
                        ferr_d = 1'b1;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_FIRE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (l3_done) begin
                    score_d = l3_score;
                    real_d  = l3_decision;
                    tmo_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else if (timer_q == TMR_LAST) begin
                    score_d = '0;
                    real_d  = 1'b0;
                    tmo_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COLLECT;
            idx_q   <= '0;
            flat_q  <= '0;
            start_q <= 1'b0;
            timer_q <= '0;
            score_q <= '0;
            real_q  <= 1'b0;
            tmo_q   <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flat_q  <= flat_d;
            start_q <= start_d;
            timer_q <= timer_d;
            score_q <= score_d;
            real_q  <= real_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_disc_layer3_feeder.sv
// Randomized bench for disc_layer3_feeder: a frame/result-level reference
// model predicts packing, start timing, watchdog and result handshake.
module tb_disc_layer3_feeder;

    localparam int N_IN    = 32;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 64;
    localparam int FW      = N_IN * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [FW-1:0]     l3_flat_input;
    logic              l3_start;
    logic [DATA_W-1:0] l3_score;
    logic              l3_decision;
    logic              l3_done;
    logic [DATA_W-1:0] res_score;
    logic              res_real;
    logic              res_timeout;
    logic              res_valid;
    logic              res_ready;
    logic              frame_err;

    always #5 clk = ~clk;

    disc_layer3_feeder #(
        .N_IN    (N_IN),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .l3_flat_input (l3_flat_input),
        .l3_start      (l3_start),
        .l3_score      (l3_score),
        .l3_decision   (l3_decision),
        .l3_done       (l3_done),
        .res_score     (res_score),
        .res_real      (res_real),
        .res_timeout   (res_timeout),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .frame_err     (frame_err)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: frame slots as last written, and the held result.
    logic [DATA_W-1:0] slots [N_IN];
    logic [DATA_W-1:0] vals  [N_IN];
    logic [DATA_W-1:0] exp_score;
    logic              exp_real;
    logic              exp_tmo;

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] pack_slots();
        logic [FW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < N_IN; k++) r[k*DATA_W +: DATA_W] = slots[k];
        return r;
    endfunction

    task automatic fill(input int unsigned mode);
        for (int unsigned k = 0; k < N_IN; k++) begin
            case (mode)
                0:       vals[k] = '0;
                1:       vals[k] = DATA_W'(32'h0032 + k);
                default: vals[k] = DATA_W'($urandom);
            endcase
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; l3_done = 1'b0; res_ready = 1'b0;
        exp_score = '0; exp_real = 1'b0; exp_tmo = 1'b0;
        for (int unsigned k = 0; k < N_IN; k++) slots[k] = '0;
        #2;
        check_eq("rst_in_ready", FW'(in_ready), FW'(1));
        check_eq("rst_flat", l3_flat_input, pack_slots());
        check_eq("rst_start", FW'(l3_start), FW'(0));
        check_eq("rst_res_score", FW'(res_score), FW'(0));
        check_eq("rst_res_flags", FW'({res_real, res_timeout, res_valid, frame_err}), FW'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic send_elems(input int unsigned n, input bit set_last, input int unsigned max_gap);
        for (int unsigned k = 0; k < n; k++) begin
            // Gap cycles also carry stray done pulses, which must be ignored here.
            repeat ($urandom_range(max_gap, 0)) begin
                in_valid = 1'b0; in_data = DATA_W'($urandom); in_last = 1'($urandom);
                l3_done = 1'($urandom); l3_score = DATA_W'($urandom); l3_decision = 1'($urandom);
                tick();
                check_eq("gap_ready", FW'(in_ready), FW'(1));
                check_eq("gap_valid", FW'(res_valid), FW'(0));
                check_eq("gap_score", FW'(res_score), FW'(exp_score));
            end
            l3_done = 1'b0;
            in_valid = 1'b1;
            in_data = vals[k];
            in_last = set_last && (k == n - 1);
            check_eq("in_ready", FW'(in_ready), FW'(1));
            tick();
            slots[k] = vals[k];
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic expect_fire();
        check_eq("fire_start", FW'(l3_start), FW'(1));
        check_eq("fire_ready", FW'(in_ready), FW'(0));
        check_eq("fire_ferr", FW'(frame_err), FW'(0));
    endtask

    task automatic expect_ferr();
        check_eq("ferr_pulse", FW'(frame_err), FW'(1));
        check_eq("ferr_nostart", FW'(l3_start), FW'(0));
        check_eq("ferr_ready", FW'(in_ready), FW'(1));
        tick();
        check_eq("ferr_once", FW'(frame_err), FW'(0));
        check_eq("ferr_nostart2", FW'(l3_start), FW'(0));
    endtask

    // Called in the FIRE cycle; layer 3 answers lat cycles after start.
    task automatic run_result(input int unsigned lat, input logic [DATA_W-1:0] sc,
                              input logic dec, input int unsigned hold);
        logic [FW-1:0] fr;
        int unsigned endc;
        fr = pack_slots();
        check_eq("flat_at_start", l3_flat_input, fr);
        endc = (lat < TIMEOUT) ? lat : TIMEOUT;
        if (lat <= TIMEOUT) begin
            exp_score = sc; exp_real = dec; exp_tmo = 1'b0;
        end else begin
            exp_score = '0; exp_real = 1'b0; exp_tmo = 1'b1;
        end
        for (int unsigned c = 1; c <= endc + 1; c++) begin
            tick();
            if (c <= endc) begin
                check_eq("wait_valid", FW'(res_valid), FW'(0));
                check_eq("wait_start", FW'(l3_start), FW'(0));
                check_eq("wait_ready", FW'(in_ready), FW'(0));
                check_eq("wait_flat", l3_flat_input, fr);
            end
            in_valid = 1'($urandom); in_data = DATA_W'($urandom); in_last = 1'($urandom);
            l3_done = (c == lat);
            l3_score = (c == lat) ? sc : DATA_W'($urandom);
            l3_decision = (c == lat) ? dec : 1'($urandom);
        end
        check_eq("hold_valid", FW'(res_valid), FW'(1));
        check_eq("hold_score", FW'(res_score), FW'(exp_score));
        check_eq("hold_real", FW'(res_real), FW'(exp_real));
        check_eq("hold_tmo", FW'(res_timeout), FW'(exp_tmo));
        check_eq("hold_ready", FW'(in_ready), FW'(0));
        for (int unsigned h = 0; h < hold; h++) begin
            res_ready = 1'b0; in_valid = 1'b1; in_data = DATA_W'($urandom);
            l3_done = 1'($urandom); l3_score = DATA_W'($urandom); l3_decision = 1'($urandom);
            tick();
            check_eq("stall_valid", FW'(res_valid), FW'(1));
            check_eq("stall_ready", FW'(in_ready), FW'(0));
            check_eq("stall_res", FW'({res_score, res_real, res_timeout}),
                     FW'({exp_score, exp_real, exp_tmo}));
        end
        res_ready = 1'b1; in_valid = 1'b0; l3_done = 1'b0;
        tick();
        res_ready = 1'b0;
        check_eq("rel_valid", FW'(res_valid), FW'(0));
        check_eq("rel_ready", FW'(in_ready), FW'(1));
        check_eq("rel_res", FW'({res_score, res_real, res_timeout}),
                 FW'({exp_score, exp_real, exp_tmo}));
        check_eq("rel_flat", l3_flat_input, fr);
    endtask

    initial begin
        in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        l3_score = '0; l3_decision = 1'b0; l3_done = 1'b0; res_ready = 1'b0;
        do_reset();

        fill(0); send_elems(N_IN, 1'b1, 0); expect_fire();
        run_result(8, 16'hFE73, 1'b0, 0);

        fill(1); send_elems(N_IN, 1'b1, 3); expect_fire();
        run_result($urandom_range(20, 2), 16'h00D9, 1'b1, 1);

        fill(2); send_elems(N_IN, 1'b1, 1); expect_fire();
        run_result(10000, DATA_W'($urandom), 1'b1, 2);

        fill(2); send_elems(10, 1'b1, 1); expect_ferr();
        fill(2); send_elems(N_IN, 1'b1, 2); expect_fire();
        run_result(TIMEOUT, DATA_W'($urandom), 1'b1, 0);

        fill(2); send_elems(N_IN, 1'b0, 0); expect_fire();
        run_result(TIMEOUT + 1, DATA_W'($urandom), 1'b1, 20);

        fill(2); send_elems(N_IN, 1'b1, 0); expect_fire();
        run_result(1, DATA_W'($urandom), 1'b1, 0);

        // Reset in WAIT, then a late done that must be ignored.
        fill(2); send_elems(N_IN, 1'b1, 0); expect_fire();
        repeat (5) tick();
        do_reset();
        l3_done = 1'b1; l3_score = 16'h7F11; l3_decision = 1'b1;
        tick();
        l3_done = 1'b0;
        tick();
        check_eq("late_done_valid", FW'(res_valid), FW'(0));
        check_eq("late_done_score", FW'(res_score), FW'(0));
        check_eq("late_done_ready", FW'(in_ready), FW'(1));
        check_eq("late_done_start", FW'(l3_start), FW'(0));

        // Reset mid-frame; the next frame must pack from slot 0.
        fill(2); send_elems(7, 1'b0, 1);
        do_reset();
        fill(1); send_elems(N_IN, 1'b1, 1); expect_fire();
        run_result(3, 16'h8001, 1'b0, 1);

        for (int unsigned f = 0; f < 8; f++) begin
            if ($urandom_range(3, 0) == 0) begin
                fill(2); send_elems($urandom_range(N_IN - 1, 1), 1'b1, 2); expect_ferr();
            end
            fill(2); send_elems(N_IN, 1'($urandom), $urandom_range(2, 0)); expect_fire();
            run_result($urandom_range(TIMEOUT + 4, 1), DATA_W'($urandom), 1'($urandom),
                       $urandom_range(5, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
